// File: rtl/rom_scan_checker.sv
// Sweeps every ROM address once, compares the two returned words one cycle later,
// and reports mismatch count, first failing address, a port-A XOR checksum and pass/fail.
module rom_scan_checker #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ERR_CNT_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [ADDR_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]    data_a,
    input  logic [DATA_WIDTH-1:0]    data_b,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    first_err_addr,
    output logic                     first_err_valid,
    output logic [DATA_WIDTH-1:0]    checksum,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [ADDR_WIDTH-1:0]    issue_addr_q;
    logic                     issue_vld_q;
    logic                     cmp_vld_q;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic [ADDR_WIDTH-1:0]    first_addr_q;
    logic                     first_vld_q;
    logic [DATA_WIDTH-1:0]    csum_q;
    logic                     pass_q;
    logic                     start_accept;
    logic                     at_last;

    // A start is only honoured when no sweep is in flight.
    assign start_accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign at_last      = (addr_q == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (at_last) state_d = DRAIN;
            // Leave once the last issued compare has retired.
            DRAIN:   if (!cmp_vld_q) state_d = DONE;
            DONE:    if (start) state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == SCAN) || (state_q == DRAIN);
        done      = (state_q == DONE);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            issue_addr_q <= '0;
            issue_vld_q  <= 1'b0;
            cmp_vld_q    <= 1'b0;
            err_q        <= '0;
            first_addr_q <= '0;
            first_vld_q  <= 1'b0;
            csum_q       <= '0;
            pass_q       <= 1'b0;
        end else begin
            issue_addr_q <= addr_q;
            cmp_vld_q    <= issue_vld_q;

            if (start_accept) begin
                addr_q       <= '0;
                issue_vld_q  <= 1'b1;
                err_q        <= '0;
                first_addr_q <= '0;
                first_vld_q  <= 1'b0;
                csum_q       <= '0;
                pass_q       <= 1'b0;
            end else begin
                if (state_q == SCAN) begin
                    if (at_last) begin
                        issue_vld_q <= 1'b0;
                    end else begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                    end
                end

                // ROM data now on the bus belongs to the address issued last cycle.
                if (cmp_vld_q) begin
                    csum_q <= csum_q ^ data_a;
                    if (data_a != data_b) begin
                        if (!(&err_q)) begin
                            err_q <= err_q + ERR_CNT_WIDTH'(1);
                        end
                        if (!first_vld_q) begin
                            first_addr_q <= issue_addr_q;
                            first_vld_q  <= 1'b1;
                        end
                    end
                end

                if ((state_q == DRAIN) && !cmp_vld_q) begin
                    pass_q <= (err_q == '0);
                end
            end
        end
    end

    assign addr            = addr_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = first_addr_q;
    assign first_err_valid = first_vld_q;
    assign checksum        = csum_q;

endmodule

// File: tb/tb_rom_scan_checker.sv
// Bench for rom_scan_checker: table of ROM patterns with expected status, plus
// hand sequences for ignored starts, mid-sweep reset and a narrow saturating counter.
module tb_rom_scan_checker;

  localparam int DEPTH = 16;
  localparam int LAT   = DEPTH + 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] addr, addr_s;
  logic [7:0] data_a, data_b, data_a_s, data_b_s;
  logic       busy, done, pass, fev;
  logic       busy_s, done_s, pass_s, fev_s;
  logic [4:0] err_count;
  logic [2:0] err_count_s;
  logic [3:0] first_addr, first_addr_s;
  logic [7:0] checksum, checksum_s;
  logic [1:0] dbg_state, dbg_state_s;

  logic [7:0] rom_a [DEPTH];
  logic [7:0] rom_b [DEPTH];

  int checks;
  int failures;

  typedef struct {
    logic [15:0] diff_mask;
    logic [7:0]  b_xor;
    logic [7:0]  a_seed;
    logic [4:0]  exp_err;
    logic [2:0]  exp_err_sat;
    logic [3:0]  exp_first;
    logic        exp_fev;
    logic        exp_pass;
  } vec_t;

  typedef struct packed {
    logic [4:0] err;
    logic [2:0] err_sat;
    logic [3:0] first;
    logic       fev;
    logic       pass;
    logic [7:0] csum;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[7];

  rom_scan_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .ERR_CNT_WIDTH(5)) u_dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .data_a(data_a), .data_b(data_b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_addr), .first_err_valid(fev), .checksum(checksum),
    .dbg_state(dbg_state)
  );

  rom_scan_checker #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .ERR_CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst(rst), .start(start), .addr(addr_s), .data_a(data_a_s), .data_b(data_b_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_count_s),
    .first_err_addr(first_addr_s), .first_err_valid(fev_s), .checksum(checksum_s),
    .dbg_state(dbg_state_s)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // registered ROM models, one cycle read latency
  always @(posedge clk) begin
    data_a   <= rom_a[addr];
    data_b   <= rom_b[addr];
    data_a_s <= rom_a[addr_s];
    data_b_s <= rom_b[addr_s];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_roms(input vec_t v);
    for (int i = 0; i < DEPTH; i++) begin
      rom_a[i] = 8'(i + 1) + v.a_seed;
      rom_b[i] = v.diff_mask[i] ? (rom_a[i] ^ v.b_xor) : rom_a[i];
    end
  endtask

  function automatic exp_t make_exp(input vec_t v);
    exp_t e;
    e.err     = v.exp_err;
    e.err_sat = v.exp_err_sat;
    e.first   = v.exp_first;
    e.fev     = v.exp_fev;
    e.pass    = v.exp_pass;
    e.csum    = '0;
    for (int i = 0; i < DEPTH; i++) e.csum = e.csum ^ (8'(i + 1) + v.a_seed);
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_flags"}, {busy, done, pass, fev}, 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_first"}, 32'(first_addr), 32'd0);
    chk({tag, "_csum"}, 32'(checksum), 32'd0);
    chk({tag, "_sat"}, {busy_s, done_s, pass_s, fev_s, err_count_s, checksum_s}, 32'd0);
  endtask

  // driver: one sweep, optional extra start pulses at cycles p1/p2
  task automatic run_sweep(input vec_t v, input int p1, input int p2);
    exp_t e;
    int   lat;
    int   addr_bad;
    int   busy_bad;
    logic [3:0] exp_addr;
    load_roms(v);
    exp_q.push_back(make_exp(v));
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk("clear_on_start", {done, pass, fev, err_count, checksum}, 32'd0);
    lat = 0;
    addr_bad = 0;
    busy_bad = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk) start = (n == p1) || (n == p2);
      @(posedge clk);
      #1;
      if (done) lat = n;
      exp_addr = (n < DEPTH - 1) ? 4'(n) : 4'(DEPTH - 1);
      if (addr !== exp_addr) addr_bad++;
      if (busy !== (n < LAT)) busy_bad++;
    end
    @(negedge clk) start = 1'b0;
    e = exp_q.pop_front();
    chk("done_latency", 32'(lat), 32'(LAT));
    chk("addr_sequence_errs", 32'(addr_bad), 32'd0);
    chk("busy_window_errs", 32'(busy_bad), 32'd0);
    chk("err_count", 32'(err_count), 32'(e.err));
    chk("first_err_addr", 32'(first_addr), 32'(e.first));
    chk("first_err_valid", 32'(fev), 32'(e.fev));
    chk("pass", 32'(pass), 32'(e.pass));
    chk("checksum", 32'(checksum), 32'(e.csum));
    chk("sat_err_count", 32'(err_count_s), 32'(e.err_sat));
    chk("sat_pass", 32'(pass_s), 32'(e.pass));
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {done, busy, addr, err_count}, {1'b1, 1'b0, 4'(DEPTH - 1), e.err});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rom_a[i] = '0;
      rom_b[i] = '0;
    end

    //  mask     xor    seed   err   sat   first fev  pass
    vecs[0] = '{16'h0000, 8'h00, 8'h00, 5'd0,  3'd0, 4'd0,  1'b0, 1'b1};
    vecs[1] = '{16'h0020, 8'hA0, 8'h00, 5'd1,  3'd1, 4'd5,  1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'h00, 5'd16, 3'd7, 4'd0,  1'b1, 1'b0};
    vecs[3] = '{16'h8000, 8'h01, 8'h00, 5'd1,  3'd1, 4'd15, 1'b1, 1'b0};
    vecs[4] = '{16'h0001, 8'h80, 8'h00, 5'd1,  3'd1, 4'd0,  1'b1, 1'b0};
    vecs[5] = '{16'h0C30, 8'h11, 8'h33, 5'd4,  3'd4, 4'd4,  1'b1, 1'b0};
    vecs[6] = '{16'h0000, 8'h00, 8'h5A, 5'd0,  3'd0, 4'd0,  1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    @(negedge clk) rst = 1'b0;

    // table loop; every sweep after the first restarts from DONE
    foreach (vecs[k]) run_sweep(vecs[k], -1, -1);

    // starts while busy are ignored
    run_sweep(vecs[1], 3, 10);

    // mid-sweep reset
    load_roms(vecs[2]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check_reset_values("midsweep_rst");
    @(negedge clk) rst = 1'b0;
    run_sweep(vecs[0], -1, -1);

    // failing sweep followed by a matching sweep started from DONE
    run_sweep(vecs[5], -1, -1);
    run_sweep(vecs[6], -1, -1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
